// File: rtl/axis_frame_gen.sv
// axis_frame_gen: command-driven AXI-Stream frame source.
// Each accepted command emits one frame of incrementing bytes starting at a seed.
// The final beat can carry a bad-frame mark in tuser.
// It keeps frame and byte counters for end-to-end checks.
// Optional macro AXIS_FRAME_GEN_STATUS_EN adds FIFO status pulse counters
// (good_count, bad_count, ovf_count).
module axis_frame_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int USER_WIDTH  = 1,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [7:0]            cmd_seed,
  input  logic                  cmd_bad,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  busy,
  output logic [31:0]           frame_count,
  output logic [31:0]           byte_count
`ifdef AXIS_FRAME_GEN_STATUS_EN
  ,
  input  logic                  status_good_frame,
  input  logic                  status_bad_frame,
  input  logic                  status_overflow,
  output logic [31:0]           good_count,
  output logic [31:0]           bad_count,
  output logic [31:0]           ovf_count
`endif
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [LEN_WIDTH:0] KW_L = (LEN_WIDTH + 1)'(KEEP_WIDTH);

  state_t               state;
  // Bytes still to send, including the beat currently presented.
  logic [LEN_WIDTH-1:0] rem_bytes;
  // Value of lane 0 of the beat currently presented.
  logic [7:0]           base_byte;
  logic                 bad_q;

  logic                  accept;
  logic                  hs;
  logic [LEN_WIDTH-1:0]  nxt_rem;
  logic [7:0]            nxt_base;
  logic                  nxt_bad;
  logic                  nxt_last;
  logic [KEEP_WIDTH-1:0] nxt_mask;
  logic [DATA_WIDTH-1:0] nxt_data;

  function automatic logic [31:0] popcount(input logic [KEEP_WIDTH-1:0] k);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) n = n + 32'(k[i]);
    return n;
  endfunction

  assign accept = (state == IDLE) && cmd_valid && cmd_ready;
  assign hs     = m_axis_tvalid && m_axis_tready;

  // Build the beat to present next: the first beat of a new command, or the successor of the current beat.
  always_comb begin
    if (accept) begin
      nxt_rem  = (cmd_len == '0) ? LEN_WIDTH'(1) : cmd_len;
      nxt_base = cmd_seed;
      nxt_bad  = cmd_bad;
    end else begin
      nxt_rem  = rem_bytes - LEN_WIDTH'(KEEP_WIDTH);
      nxt_base = base_byte + 8'(KEEP_WIDTH);
      nxt_bad  = bad_q;
    end
    nxt_last = ({1'b0, nxt_rem} <= KW_L);
    nxt_mask = '0;
    nxt_data = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      nxt_mask[i] = !nxt_last || ({1'b0, nxt_rem} > (LEN_WIDTH + 1)'(i));
      nxt_data[i*8 +: 8] = nxt_mask[i] ? (nxt_base + 8'(i)) : 8'h00;
    end
  end

  // Frame FSM with registered handshake, payload and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      rem_bytes     <= '0;
      base_byte     <= '0;
      bad_q         <= 1'b0;
      frame_count   <= '0;
      byte_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            state         <= SEND;
            cmd_ready     <= 1'b0;
            busy          <= 1'b1;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= nxt_data;
            m_axis_tkeep  <= (KEEP_ENABLE != 0) ? nxt_mask : {KEEP_WIDTH{1'b1}};
            m_axis_tlast  <= nxt_last;
            m_axis_tuser  <= {USER_WIDTH{nxt_bad && nxt_last}};
            rem_bytes     <= nxt_rem;
            base_byte     <= nxt_base;
            bad_q         <= nxt_bad;
          end
        end
        SEND: begin
          if (hs) begin
            byte_count <= byte_count + popcount(m_axis_tkeep);
            if (m_axis_tlast) begin
              state         <= IDLE;
              frame_count   <= frame_count + 32'd1;
              cmd_ready     <= 1'b1;
              busy          <= 1'b0;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              m_axis_tuser  <= '0;
            end else begin
              m_axis_tdata  <= nxt_data;
              m_axis_tkeep  <= (KEEP_ENABLE != 0) ? nxt_mask : {KEEP_WIDTH{1'b1}};
              m_axis_tlast  <= nxt_last;
              m_axis_tuser  <= {USER_WIDTH{nxt_bad && nxt_last}};
              rem_bytes     <= nxt_rem;
              base_byte     <= nxt_base;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_FRAME_GEN_STATUS_EN
  // Count FIFO status pulses, one increment per cycle a pulse is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_count <= '0;
      bad_count  <= '0;
      ovf_count  <= '0;
    end else begin
      if (status_good_frame) good_count <= good_count + 32'd1;
      if (status_bad_frame)  bad_count  <= bad_count + 32'd1;
      if (status_overflow)   ovf_count  <= ovf_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb_axis_frame_gen: directed bench for axis_frame_gen with a 32-bit stream.
module tb_axis_frame_gen;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic [7:0]  cmd_seed;
  logic        cmd_bad;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [0:0]  tuser;
  logic        busy;
  logic [31:0] frame_count;
  logic [31:0] byte_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_data [16];
  logic [3:0]  cap_keep [16];
  logic        cap_last [16];
  logic        cap_user [16];
  int          cap_n;

  axis_frame_gen #(
    .DATA_WIDTH (32),
    .KEEP_ENABLE(1),
    .KEEP_WIDTH (4),
    .USER_WIDTH (1),
    .LEN_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .cmd_seed     (cmd_seed),
    .cmd_bad      (cmd_bad),
    .m_axis_tdata (tdata),
    .m_axis_tkeep (tkeep),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast),
    .m_axis_tuser (tuser),
    .busy         (busy),
    .frame_count  (frame_count),
    .byte_count   (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for cmd_ready at a falling edge, present one command, check acceptance.
  task automatic issue_cmd(input logic [15:0] len, input logic [7:0] seed, input logic bad);
    int cyc;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_seed  = seed;
    cmd_bad   = bad;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_len   = 16'hFFFF;
    cmd_seed  = 8'h55;
    cmd_bad   = ~bad;
    check("first_beat_latency", 64'(tvalid), 64'(1));
    check("cmd_ready_low", 64'(cmd_ready), 64'(0));
    check("busy_high", 64'(busy), 64'(1));
  endtask

  // Issue a command and collect every beat; rnd selects random tready.
  task automatic run_frame(input logic [15:0] len, input logic [7:0] seed, input logic bad, input bit rnd);
    int          cyc;
    bit          done;
    bit          stalled;
    logic [37:0] held;
    cap_n = 0;
    issue_cmd(len, seed, bad);
    done    = 1'b0;
    stalled = 1'b0;
    held    = '0;
    cyc     = 0;
    while (!done && cyc < 400) begin
      check("no_gap", 64'(tvalid), 64'(1));
      if (stalled) check("stall_stable", 64'({tdata, tkeep, tlast, tuser}), 64'(held));
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid && tready) begin
        if (cap_n < 16) begin
          cap_data[cap_n] = tdata;
          cap_keep[cap_n] = tkeep;
          cap_last[cap_n] = tlast;
          cap_user[cap_n] = tuser[0];
        end
        cap_n++;
        if (tlast) done = 1'b1;
        stalled = 1'b0;
      end else begin
        stalled = tvalid;
        held    = {tdata, tkeep, tlast, tuser};
      end
      @(negedge clk);
      cyc++;
    end
    check("frame_done", 64'(done), 64'(1));
    check("post_tvalid", 64'(tvalid), 64'(0));
    check("post_busy", 64'(busy), 64'(0));
    check("post_cmd_ready", 64'(cmd_ready), 64'(1));
  endtask

  // Compare the captured frame against the byte-sequence model.
  task automatic check_model(input int len, input int seed, input logic bad);
    int L, beats, rem, n;
    logic [31:0] d;
    L     = (len == 0) ? 1 : len;
    beats = (L + 3) / 4;
    check("model_beats", 64'(cap_n), 64'(beats));
    for (int b = 0; b < cap_n && b < 16; b++) begin
      rem = L - b * 4;
      n   = (rem >= 4) ? 4 : rem;
      d   = '0;
      for (int i = 0; i < n; i++) d[i*8 +: 8] = 8'((seed + b * 4 + i) % 256);
      check("model_data", 64'(cap_data[b]), 64'(d));
      check("model_keep", 64'(cap_keep[b]), 64'((1 << n) - 1));
      check("model_last", 64'(cap_last[b]), 64'(b == beats - 1));
      check("model_user", 64'(cap_user[b]), 64'((b == beats - 1) && bad));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_seed  = '0;
    cmd_bad   = 1'b0;
    tready    = 1'b1;
    cap_n     = 0;
    repeat (3) @(negedge clk);

    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_tlast", 64'(tlast), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_payload", 64'({tdata, tkeep, tuser}), 64'(0));
    check("rst_frame_count", 64'(frame_count), 64'(0));
    check("rst_byte_count", 64'(byte_count), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // len 10, seed 0x10: three beats, partial last beat.
    run_frame(16'd10, 8'h10, 1'b0, 1'b0);
    check("t1_beats", 64'(cap_n), 64'(3));
    check("t1_d0", 64'(cap_data[0]), 64'h13121110);
    check("t1_d1", 64'(cap_data[1]), 64'h17161514);
    check("t1_d2", 64'(cap_data[2]), 64'h00001918);
    check("t1_k0", 64'(cap_keep[0]), 64'hF);
    check("t1_k1", 64'(cap_keep[1]), 64'hF);
    check("t1_k2", 64'(cap_keep[2]), 64'h3);
    check("t1_last01", 64'({cap_last[0], cap_last[1]}), 64'(0));
    check("t1_last2", 64'(cap_last[2]), 64'(1));
    check("t1_user", 64'({cap_user[0], cap_user[1], cap_user[2]}), 64'(0));
    check("t1_frame_count", 64'(frame_count), 64'(1));
    check("t1_byte_count", 64'(byte_count), 64'(10));

    // len 0 treated as 1, bad frame.
    run_frame(16'd0, 8'hFF, 1'b1, 1'b0);
    check("t2_beats", 64'(cap_n), 64'(1));
    check("t2_d0", 64'(cap_data[0]), 64'h000000FF);
    check("t2_k0", 64'(cap_keep[0]), 64'h1);
    check("t2_last", 64'(cap_last[0]), 64'(1));
    check("t2_user", 64'(cap_user[0]), 64'(1));
    check("t2_frame_count", 64'(frame_count), 64'(2));
    check("t2_byte_count", 64'(byte_count), 64'(11));

    // Byte wrap across 0xFF.
    run_frame(16'd8, 8'hFE, 1'b0, 1'b0);
    check("t3_beats", 64'(cap_n), 64'(2));
    check("t3_d0", 64'(cap_data[0]), 64'h0100FFFE);
    check("t3_d1", 64'(cap_data[1]), 64'h05040302);
    check("t3_k1", 64'(cap_keep[1]), 64'hF);
    check("t3_last", 64'({cap_last[0], cap_last[1]}), 64'b01);
    check("t3_byte_count", 64'(byte_count), 64'(19));

    // Exact multiple of the beat width: single full last beat.
    run_frame(16'd4, 8'h00, 1'b1, 1'b0);
    check("t4_d0", 64'(cap_data[0]), 64'h03020100);
    check("t4_k0", 64'(cap_keep[0]), 64'hF);
    check("t4_last_user", 64'({cap_last[0], cap_user[0]}), 64'b11);
    check("t4_byte_count", 64'(byte_count), 64'(23));

    // Random backpressure over a 40-byte frame.
    run_frame(16'd40, 8'h80, 1'b1, 1'b1);
    check_model(40, 8'h80, 1'b1);
    check("t5_frame_count", 64'(frame_count), 64'(5));
    check("t5_byte_count", 64'(byte_count), 64'(63));

    // Reset during beat 2 of a 5-beat frame.
    tready = 1'b1;
    issue_cmd(16'd20, 8'h60, 1'b0);
    @(negedge clk);
    check("t6_beat2_data", 64'(tdata), 64'h67666564);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(tvalid), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_frame_count", 64'(frame_count), 64'(0));
    check("t6_rst_byte_count", 64'(byte_count), 64'(0));
    @(negedge clk);
    check("t6_held_tvalid", 64'(tvalid), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(16'd5, 8'h40, 1'b0, 1'b0);
    check("t6_beats", 64'(cap_n), 64'(2));
    check("t6_d0", 64'(cap_data[0]), 64'h43424140);
    check("t6_d1", 64'(cap_data[1]), 64'h00000044);
    check("t6_k1", 64'(cap_keep[1]), 64'h1);
    check("t6_frame_count", 64'(frame_count), 64'(1));
    check("t6_byte_count", 64'(byte_count), 64'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
